// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: reads bursts (or continuous drains) from a FIFO and streams the words on valid/ready.
// Latency: rd_latency cycles from fifo_rd to capture, then one cycle to m_valid.
// Backpressure: reads are credited against buffer space, so m_ready low stalls reads and never drops words.
module fifo_drain_ctrl #(
  parameter int data_width = 8,
  parameter int buf_depth  = 4,
  parameter int rd_latency = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            burst_len,
  input  logic                  stop,
  output logic                  fifo_rd,
  input  logic [data_width-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            rd_count,
  output logic                  err_underflow
);

  localparam int AW = $clog2(buf_depth);
  // Wide enough to hold occupancy plus every read still in flight.
  localparam int CW = $clog2(buf_depth + rd_latency + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t                state;
  logic [7:0]            remaining;
  logic                  continuous;
  logic [rd_latency-1:0] rd_pipe;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         occ;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [data_width-1:0] mem [buf_depth];
  logic                  capture;
  logic                  pop;
  logic                  credit_ok;
  logic                  want_read;

  // A read flag leaving the pipe means fifo_data now carries that read's word.
  assign capture   = rd_pipe[rd_latency-1];
  assign pop       = m_valid && m_ready;
  // Only issue a read if its word is guaranteed a free buffer slot on arrival.
  assign credit_ok = (occ + inflight) < CW'(buf_depth);
  assign want_read = (continuous || (remaining != 8'd0)) && !stop;
  assign fifo_rd   = (state == S_DRAIN) && !fifo_empty && want_read && credit_ok;

  assign m_valid = (occ != '0);
  assign m_data  = mem[rd_ptr];

  // Delay line of issued reads, plus a running count of reads not yet captured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pipe  <= '0;
      inflight <= '0;
    end else begin
      rd_pipe[0] <= fifo_rd;
      for (int i = 1; i < rd_latency; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      inflight <= inflight + CW'(fifo_rd) - CW'(capture);
    end
  end

  // Circular capture buffer: write arriving words at the tail, pop the head on transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < buf_depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (capture) begin
        mem[wr_ptr] <= fifo_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ <= occ + CW'(capture) - CW'(pop);
    end
  end

  // Burst sequencing IDLE -> DRAIN -> FLUSH -> DONE with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      remaining     <= 8'd0;
      continuous    <= 1'b0;
      rd_count      <= 8'd0;
      err_underflow <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fifo_underflow) begin
        err_underflow <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining     <= burst_len;
            continuous    <= (burst_len == 8'd0);
            rd_count      <= 8'd0;
            // An underflow in the launch cycle still belongs to the new burst.
            err_underflow <= fifo_underflow;
            busy          <= 1'b1;
            state         <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_rd) begin
            if (!continuous) begin
              remaining <= remaining - 8'd1;
            end
            if (rd_count != 8'hFF) begin
              rd_count <= rd_count + 8'd1;
            end
          end
          if (stop || (fifo_rd && !continuous && (remaining == 8'd1))) begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Wait for every issued word to be captured and handed downstream.
          if ((inflight == '0) && (occ == '0)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
